// File: rtl/countdown_timer_disp_pkg.sv
// Shared types, segment codes and the START_VAL to BCD helper for the
// countdown timer.
package cdt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DEFUSED = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // 7-segment codes, {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [7:0] SEG7_0     = 8'h3F;
    localparam logic [7:0] SEG7_1     = 8'h06;
    localparam logic [7:0] SEG7_2     = 8'h5B;
    localparam logic [7:0] SEG7_3     = 8'h4F;
    localparam logic [7:0] SEG7_4     = 8'h66;
    localparam logic [7:0] SEG7_5     = 8'h6D;
    localparam logic [7:0] SEG7_6     = 8'h7D;
    localparam logic [7:0] SEG7_7     = 8'h07;
    localparam logic [7:0] SEG7_8     = 8'h7F;
    localparam logic [7:0] SEG7_9     = 8'h6F;
    localparam logic [7:0] SEG7_BLANK = 8'h00;
    localparam logic [7:0] CAT_OFF    = 8'hFF;

    // Converts a decimal integer into up to eight packed BCD digits.
    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_disp_if.sv
// Control/status bundle between the game controller (master) and the
// countdown timer (slave).
interface countdown_timer_disp_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  success;
    logic                  load;
    logic [7:0]            cat;
    logic [7:0]            seg;
    logic [4*DIGITS-1:0]   bcd;
    logic                  running;
    logic                  defused;
    logic                  expired;

    modport master (
        output start, success, load,
        input  cat, seg, bcd, running, defused, expired
    );

    modport slave (
        input  start, success, load,
        output cat, seg, bcd, running, defused, expired
    );
endinterface

// File: rtl/countdown_timer_disp_seg7.sv
// BCD digit to 7-segment decoder; non-BCD codes show blank, dp always off.
module bcd_to_seg7
    import cdt_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG7_BLANK;
        case (bcd)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer_disp.sv
// BCD countdown timer with multiplexed common-cathode display driver.
// Optional build macro CDT_EXPIRE_BLINK_EN: blink the all-zero display
// in EXPIRED, toggling once per tick period.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | loaded with START_VAL, waiting for start
//  RUN     | counting down (start=0 pauses in place)
//  DEFUSED | success seen, count frozen until load/rst
//  EXPIRED | count reached zero, frozen until load/rst
module countdown_timer_disp #(
    parameter int DIGITS    = 2,
    parameter int START_VAL = 20,
    parameter int TICK_DIV  = 30,
    parameter int SCAN_DIV  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_timer_disp_if.slave   bus
);
    import cdt_pkg::*;

    localparam int BW     = 4 * DIGITS;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [31:0]       START_BCD32 = to_bcd(START_VAL);
    localparam logic [BW-1:0]     START_BCD   = START_BCD32[BW-1:0];
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0]        IDX_LAST    = 3'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_dec;
    logic [TICK_W-1:0]   tick_q;
    logic [SCAN_W-1:0]   scan_q;
    logic [2:0]          idx_q;
    logic                blank_q;
    logic [7:0]          cat_q, seg_q, cat_next, seg_code;
    logic [3:0]          digit;
    logic                running_q, defused_q, expired_q;
    logic                running_d, defused_d, expired_d;
    logic                tick_wrap, bcd_zero, step;

    // Decimal decrement with a borrow ripple across all digits
    function automatic logic [BW-1:0] bcd_decrement(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick_wrap = (tick_q == TICK_LAST);
    assign bcd_zero  = (bcd_q == '0);
    assign bcd_dec   = bcd_decrement(bcd_q);
    // A success on the wrap cycle wins, so the decrement is suppressed
    assign step      = (state_q == RUN) && bus.start && !bus.success
                       && !bcd_zero && tick_wrap;

    // State register plus registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            defused_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            defused_q <= defused_d;
            expired_q <= expired_d;
        end
    end

    // Next-state logic; load overrides everything in every state
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN: begin
                    if (bus.success)                 state_d = DEFUSED;
                    else if (bcd_zero)               state_d = EXPIRED;
                    else if (step && bcd_dec == '0)  state_d = EXPIRED;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Flags are taken from the next state so the registers match state_q
    always_comb begin
        running_d = (state_d == RUN);
        defused_d = (state_d == DEFUSED);
        expired_d = (state_d == EXPIRED);
    end

    // BCD down-counter
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            bcd_q <= START_BCD;
        end else if (step) begin
            bcd_q <= bcd_dec;
        end
    end

    // Tick divider: counts in RUN while enabled, holds on pause
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            tick_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) tick_q <= '0;
                end
                RUN: begin
                    if (bus.start && !bus.success && !bcd_zero)
                        tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
                end
                EXPIRED: begin
`ifdef CDT_EXPIRE_BLINK_EN
                    tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
`endif
                end
                default: tick_q <= tick_q;
            endcase
        end
    end

    // Blank phase for the expired display; starts visible
    always_ff @(posedge clk) begin
        if (rst || bus.load || state_q != EXPIRED) begin
            blank_q <= 1'b0;
        end else begin
`ifdef CDT_EXPIRE_BLINK_EN
            if (tick_wrap) blank_q <= ~blank_q;
`else
            blank_q <= 1'b0;
`endif
        end
    end

    // Scan divider and digit index, free-running in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Select the active digit and its cathode
    always_comb begin
        digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) digit = bcd_q[i*4 +: 4];
        end
        cat_next        = CAT_OFF;
        cat_next[idx_q] = 1'b0;
    end

    bcd_to_seg7 u_seg7 (
        .bcd (digit),
        .seg (seg_code)
    );

    // cat and seg share one register stage so they never skew
    always_ff @(posedge clk) begin
        if (rst || blank_q) begin
            cat_q <= CAT_OFF;
            seg_q <= SEG7_BLANK;
        end else begin
            cat_q <= cat_next;
            seg_q <= seg_code;
        end
    end

    assign bus.cat     = cat_q;
    assign bus.seg     = seg_q;
    assign bus.bcd     = bcd_q;
    assign bus.running = running_q;
    assign bus.defused = defused_q;
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_disp.sv
// Directed testbench for countdown_timer_disp.
module tb_countdown_timer_disp;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    countdown_timer_disp_if #(.DIGITS(2)) bus0 ();
    countdown_timer_disp_if #(.DIGITS(3)) bus1 ();
    countdown_timer_disp_if #(.DIGITS(2)) bus2 ();

    countdown_timer_disp #(.DIGITS(2), .START_VAL(20), .TICK_DIV(4), .SCAN_DIV(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    countdown_timer_disp #(.DIGITS(3), .START_VAL(20), .TICK_DIV(4), .SCAN_DIV(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    countdown_timer_disp #(.DIGITS(2), .START_VAL(0), .TICK_DIV(4), .SCAN_DIV(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        bus0.load = 1'b1;
        cyc();
        bus0.load = 1'b0;
        bus0.start = 1'b0;
        bus0.success = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.start = 0; bus0.success = 0; bus0.load = 0;
        bus1.start = 0; bus1.success = 0; bus1.load = 0;
        bus2.start = 0; bus2.success = 0; bus2.load = 0;
        cyc();
        cyc();
        checks++; if (bus0.cat !== 8'hFF) begin failures++; $display("FAIL rst_cat got=%h exp=FF", bus0.cat); end
        checks++; if (bus0.seg !== 8'h00) begin failures++; $display("FAIL rst_seg got=%h exp=00", bus0.seg); end
        checks++; if (bus0.bcd !== 8'h20) begin failures++; $display("FAIL rst_bcd got=%h exp=20", bus0.bcd); end
        checks++; if ({bus0.running, bus0.defused, bus0.expired} !== 3'b000) begin
            failures++; $display("FAIL rst_flags got=%b exp=000", {bus0.running, bus0.defused, bus0.expired}); end
        checks++; if (bus1.bcd !== 12'h020) begin failures++; $display("FAIL rst_bcd3 got=%h exp=020", bus1.bcd); end
        checks++; if (bus2.bcd !== 8'h00) begin failures++; $display("FAIL rst_bcd_zero got=%h exp=00", bus2.bcd); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] cat0_exp [6];
        logic [7:0] seg0_exp [6];
        logic [7:0] cat1_exp [6];
        logic [7:0] seg1_exp [6];
        cat0_exp = '{8'hFE, 8'hFD, 8'hFE, 8'hFD, 8'hFE, 8'hFD};
        seg0_exp = '{8'h3F, 8'h5B, 8'h3F, 8'h5B, 8'h3F, 8'h5B};
        cat1_exp = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB};
        seg1_exp = '{8'h3F, 8'h3F, 8'h5B, 8'h5B, 8'h3F, 8'h3F};
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++; if (bus0.cat !== cat0_exp[i] || bus0.seg !== seg0_exp[i]) begin
                failures++; $display("FAIL scan2_%0d got cat=%h seg=%h exp cat=%h seg=%h",
                                     i, bus0.cat, bus0.seg, cat0_exp[i], seg0_exp[i]); end
            checks++; if (bus1.cat !== cat1_exp[i] || bus1.seg !== seg1_exp[i]) begin
                failures++; $display("FAIL scan3_%0d got cat=%h seg=%h exp cat=%h seg=%h",
                                     i, bus1.cat, bus1.seg, cat1_exp[i], seg1_exp[i]); end
        end
    endtask

    task automatic test_countdown();
        bus0.start = 1'b1;
        cyc();
        checks++; if (bus0.running !== 1'b1) begin failures++; $display("FAIL cd_running got=%b exp=1", bus0.running); end
        repeat (3) cyc();
        checks++; if (bus0.bcd !== 8'h20) begin failures++; $display("FAIL cd_pre_step got=%h exp=20", bus0.bcd); end
        cyc();
        checks++; if (bus0.bcd !== 8'h19) begin failures++; $display("FAIL cd_first_step got=%h exp=19", bus0.bcd); end
        repeat (36) cyc();
        checks++; if (bus0.bcd !== 8'h10) begin failures++; $display("FAIL cd_ten_steps got=%h exp=10", bus0.bcd); end
        repeat (39) cyc();
        checks++; if (bus0.bcd !== 8'h01 || bus0.expired !== 1'b0) begin
            failures++; $display("FAIL cd_last_one got bcd=%h exp=%b exp bcd=01 exp=0", bus0.bcd, bus0.expired); end
        cyc();
        checks++; if (bus0.bcd !== 8'h00 || bus0.expired !== 1'b1 || bus0.running !== 1'b0) begin
            failures++; $display("FAIL cd_expire got bcd=%h exp=%b run=%b exp bcd=00 1 0",
                                 bus0.bcd, bus0.expired, bus0.running); end
        repeat (50) cyc();
        checks++; if (bus0.bcd !== 8'h00 || bus0.expired !== 1'b1) begin
            failures++; $display("FAIL cd_hold got bcd=%h exp=%b exp bcd=00 1", bus0.bcd, bus0.expired); end
    endtask

    task automatic test_load_expired();
        do_load();
        checks++; if (bus0.bcd !== 8'h20 || {bus0.running, bus0.defused, bus0.expired} !== 3'b000) begin
            failures++; $display("FAIL load_exp got bcd=%h flags=%b exp bcd=20 flags=000",
                                 bus0.bcd, {bus0.running, bus0.defused, bus0.expired}); end
    endtask

    task automatic test_defuse();
        bus0.start = 1'b1;
        cyc();
        repeat (28) cyc();
        checks++; if (bus0.bcd !== 8'h13) begin failures++; $display("FAIL def_reach13 got=%h exp=13", bus0.bcd); end
        repeat (3) cyc();
        bus0.success = 1'b1;
        cyc();
        checks++; if (bus0.defused !== 1'b1 || bus0.running !== 1'b0) begin
            failures++; $display("FAIL def_flag got def=%b run=%b exp 1 0", bus0.defused, bus0.running); end
        checks++; if (bus0.bcd !== 8'h13) begin failures++; $display("FAIL def_hold got=%h exp=13", bus0.bcd); end
        bus0.success = 1'b0;
        bus0.start = 1'b0;
        repeat (5) cyc();
        bus0.start = 1'b1;
        repeat (10) cyc();
        checks++; if (bus0.bcd !== 8'h13 || bus0.defused !== 1'b1) begin
            failures++; $display("FAIL def_terminal got bcd=%h def=%b exp 13 1", bus0.bcd, bus0.defused); end
        do_load();
    endtask

    task automatic test_pause();
        bus0.start = 1'b1;
        cyc();
        repeat (14) cyc();
        checks++; if (bus0.bcd !== 8'h17) begin failures++; $display("FAIL pause_reach17 got=%h exp=17", bus0.bcd); end
        bus0.start = 1'b0;
        repeat (10) cyc();
        checks++; if (bus0.bcd !== 8'h17 || bus0.running !== 1'b1) begin
            failures++; $display("FAIL pause_hold got bcd=%h run=%b exp 17 1", bus0.bcd, bus0.running); end
        bus0.start = 1'b1;
        cyc();
        checks++; if (bus0.bcd !== 8'h17) begin failures++; $display("FAIL pause_resume1 got=%h exp=17", bus0.bcd); end
        cyc();
        checks++; if (bus0.bcd !== 8'h16) begin failures++; $display("FAIL pause_resume2 got=%h exp=16", bus0.bcd); end
    endtask

    task automatic test_load_run();
        repeat (5) cyc();
        checks++; if (bus0.bcd !== 8'h15) begin failures++; $display("FAIL ldrun_pre got=%h exp=15", bus0.bcd); end
        do_load();
        checks++; if (bus0.bcd !== 8'h20 || bus0.running !== 1'b0) begin
            failures++; $display("FAIL ldrun got bcd=%h run=%b exp 20 0", bus0.bcd, bus0.running); end
        bus0.start = 1'b1;
        repeat (6) cyc();
        bus0.success = 1'b1;
        bus0.load = 1'b1;
        cyc();
        bus0.load = 1'b0;
        bus0.success = 1'b0;
        bus0.start = 1'b0;
        checks++; if ({bus0.running, bus0.defused, bus0.expired} !== 3'b000 || bus0.bcd !== 8'h20) begin
            failures++; $display("FAIL ld_success got flags=%b bcd=%h exp 000 20",
                                 {bus0.running, bus0.defused, bus0.expired}, bus0.bcd); end
    endtask

    task automatic test_start_zero();
        bus2.start = 1'b1;
        cyc();
        checks++; if (bus2.running !== 1'b1 || bus2.expired !== 1'b0) begin
            failures++; $display("FAIL zero_run got run=%b exp=%b exp 1 0", bus2.running, bus2.expired); end
        cyc();
        checks++; if (bus2.expired !== 1'b1 || bus2.running !== 1'b0 || bus2.bcd !== 8'h00) begin
            failures++; $display("FAIL zero_expire got exp=%b run=%b bcd=%h exp 1 0 00",
                                 bus2.expired, bus2.running, bus2.bcd); end
        repeat (10) cyc();
        checks++; if (bus2.bcd !== 8'h00) begin failures++; $display("FAIL zero_no_underflow got=%h exp=00", bus2.bcd); end
        bus2.start = 1'b0;
    endtask

`ifdef CDT_EXPIRE_BLINK_EN
    task automatic test_blink();
        bus0.start = 1'b1;
        cyc();
        repeat (80) cyc();
        checks++; if (bus0.expired !== 1'b1) begin failures++; $display("FAIL blink_expired got=%b exp=1", bus0.expired); end
        repeat (2) cyc();
        checks++; if (bus0.cat === 8'hFF) begin failures++; $display("FAIL blink_visible1 got cat=%h exp not FF", bus0.cat); end
        repeat (4) cyc();
        checks++; if (bus0.cat !== 8'hFF || bus0.seg !== 8'h00) begin
            failures++; $display("FAIL blink_blank got cat=%h seg=%h exp FF 00", bus0.cat, bus0.seg); end
        repeat (4) cyc();
        checks++; if (bus0.cat === 8'hFF || bus0.seg !== 8'h3F) begin
            failures++; $display("FAIL blink_visible2 got cat=%h seg=%h exp active 3F", bus0.cat, bus0.seg); end
        do_load();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        test_reset();
        test_scan();
        test_countdown();
        test_load_expired();
        test_defuse();
        test_pause();
        test_load_run();
        test_start_zero();
`ifdef CDT_EXPIRE_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
